// File: rtl/cmp_bist_driver.sv
// rtl/cmp_bist_driver.sv - LFSR-driven self-test master and checker for the magnitude comparator
// Optional first-failure capture ports are enabled by defining CMP_BIST_FIRST_FAIL_EN.
module cmp_bist_driver #(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      NUM_VECTORS  = 256,
   parameter int unsigned      RESP_LATENCY = 1,
   parameter logic [WIDTH-1:0] SEED         = 8'hA5,
   parameter logic [WIDTH-1:0] POLY         = 8'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic             Greater,
   input  logic             Less,
   input  logic             Equal,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      vec_count
`ifdef CMP_BIST_FIRST_FAIL_EN
   ,
   output logic             first_fail_valid,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b,
   output logic [2:0]       first_fail_flags
`endif
);

   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
   localparam bit               HAS_WAIT = (RESP_LATENCY > 0);
   localparam logic [3:0]       LAT_LAST = HAS_WAIT ? 4'(RESP_LATENCY - 1) : 4'd0;
   localparam logic [15:0]      NUM_LAST = 16'(NUM_VECTORS);

   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lfsr;
   logic [3:0]       wait_cnt;
   logic [2:0]       expected;
   logic [2:0]       observed;
   logic             mismatch;
   logic             last_vec;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Golden result comes from the registered operands, so it matches what the comparator sees.
   assign expected = {A > B, A < B, A == B};
   assign observed = {Greater, Less, Equal};
   assign mismatch = (observed != expected);
   assign last_vec = ((vec_count + 16'd1) == NUM_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = DRIVE;
         DRIVE:      state_nxt = HAS_WAIT ? WAIT : CHECK;
         WAIT:       if (wait_cnt == LAT_LAST) state_nxt = CHECK;
         CHECK:      state_nxt = last_vec ? DONE : DRIVE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= SEED_EFF;
         A         <= '0;
         B         <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         vec_count <= '0;
`ifdef CMP_BIST_FIRST_FAIL_EN
         first_fail_valid <= 1'b0;
         first_fail_a     <= '0;
         first_fail_b     <= '0;
         first_fail_flags <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  lfsr      <= SEED_EFF;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  vec_count <= '0;
`ifdef CMP_BIST_FIRST_FAIL_EN
                  first_fail_valid <= 1'b0;
                  first_fail_a     <= '0;
                  first_fail_b     <= '0;
                  first_fail_flags <= '0;
`endif
               end
            end
            DRIVE: begin
               // Every fourth vector forces equality; the rest pair with the previous A.
               A <= lfsr;
               if (vec_count[1:0] == 2'b11) B <= lfsr;
               else if (vec_count == '0)    B <= ~SEED;
               else                         B <= A;
               lfsr     <= lfsr_step(lfsr);
               wait_cnt <= '0;
            end
            WAIT: wait_cnt <= wait_cnt + 4'd1;
            CHECK: begin
               if (mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
`ifdef CMP_BIST_FIRST_FAIL_EN
               if (mismatch && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_a     <= A;
                  first_fail_b     <= B;
                  first_fail_flags <= observed;
               end
`endif
               vec_count <= vec_count + 16'd1;
               if (last_vec) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_count == '0) && !mismatch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_bist_driver.sv
// tb/tb_cmp_bist_driver.sv - scoreboard bench for cmp_bist_driver with a faultable comparator model
module tb_cmp_bist_driver;

   localparam int NV  = 16;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  A, B;
   logic        Greater, Less, Equal;
   logic        busy, done, pass;
   logic [15:0] err_count, vec_count;
`ifdef CMP_BIST_FIRST_FAIL_EN
   logic        first_fail_valid;
   logic [7:0]  first_fail_a, first_fail_b;
   logic [2:0]  first_fail_flags;
`endif

   int fmode = 0;
   int cyc = 0;
   int checks = 0;
   int passes = 0;

   cmp_bist_driver #(
      .WIDTH(8), .NUM_VECTORS(NV), .RESP_LATENCY(LAT), .SEED(8'hA5), .POLY(8'hB8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .Greater(Greater), .Less(Less), .Equal(Equal),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count)
`ifdef CMP_BIST_FIRST_FAIL_EN
      ,
      .first_fail_valid(first_fail_valid), .first_fail_a(first_fail_a),
      .first_fail_b(first_fail_b), .first_fail_flags(first_fail_flags)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Comparator under test: 0 ideal, 1 Greater stuck low, 2 all flags high, 3 all flags low on equal pairs
   always_comb begin
      Greater = (A > B);
      Less    = (A < B);
      Equal   = (A == B);
      case (fmode)
         1: Greater = 1'b0;
         2: {Greater, Less, Equal} = 3'b111;
         3: if (A == B) {Greater, Less, Equal} = 3'b000;
         default: ;
      endcase
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] err;
      logic [15:0] idx;
   } vec_exp_t;

   typedef struct {
      int          cycle;
      logic        pass;
      logic [15:0] err;
      logic [15:0] vec;
      logic        ffv;
      logic [7:0]  ffa;
      logic [7:0]  ffb;
      logic [2:0]  fff;
   } run_exp_t;

   vec_exp_t vq[$];
   run_exp_t rq[$];

   logic [7:0] seq_a [4];
   logic [7:0] seq_b [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: walk the operand sequence with plain arithmetic and apply each fault's error rule.
   task automatic push_run(input int mode, input int start_cyc);
      logic [7:0] s, pa, a, b;
      logic       bad, found;
      int         errs;
      run_exp_t   r;
      s = 8'hA5; pa = 8'h00; errs = 0; found = 1'b0;
      r.ffv = 1'b0; r.ffa = 8'h00; r.ffb = 8'h00; r.fff = 3'b000;
      for (int i = 0; i < NV; i++) begin
         a = s;
         if (i % 4 == 3) b = s;
         else if (i == 0) b = ~8'hA5;
         else b = pa;
         case (mode)
            1: bad = (a > b);
            2: bad = 1'b1;
            3: bad = (a == b);
            default: bad = 1'b0;
         endcase
         if (bad) begin
            errs++;
            if (!found) begin
               found = 1'b1;
               r.ffv = 1'b1; r.ffa = a; r.ffb = b;
               case (mode)
                  1: r.fff = {1'b0, a < b, a == b};
                  2: r.fff = 3'b111;
                  default: r.fff = 3'b000;
               endcase
            end
         end
         vq.push_back('{a, b, 16'(errs), 16'(i + 1)});
         pa = a;
         s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
      end
      r.cycle = start_cyc + NV * (LAT + 2) + 1;
      r.pass  = (errs == 0);
      r.err   = 16'(errs);
      r.vec   = 16'(NV);
      rq.push_back(r);
   endtask

   task automatic wait_vec(input int n);
      for (int t = 0; t < 400 && vec_count != 16'(n); t++) @(negedge clk);
      chk("wait_vec", 32'(vec_count), 32'(n));
   endtask

   task automatic issue_start(input int mode);
      fmode = mode;
      @(posedge clk); #1;
      start = 1'b1;
      push_run(mode, cyc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_run(input int mode, input bit poke, input bit check_seq, input bit check_clear);
      issue_start(mode);
      if (check_clear) begin
         chk("clr_done", 32'(done), 32'(0));
         chk("clr_pass", 32'(pass), 32'(0));
         chk("clr_vec", 32'(vec_count), 32'(0));
         chk("clr_err", 32'(err_count), 32'(0));
         chk("clr_busy", 32'(busy), 32'(1));
      end
      if (check_seq) begin
         for (int v = 0; v < 4; v++) begin
            wait_vec(v + 1);
            chk("seq_a", 32'(A), 32'(seq_a[v]));
            chk("seq_b", 32'(B), 32'(seq_b[v]));
         end
      end
      if (poke) begin
         repeat ($urandom_range(2, 30)) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      for (int t = 0; t < 400 && !done; t++) @(negedge clk);
      chk("run_done", 32'(done), 32'(1));
      @(negedge clk);
   endtask

   // Monitor: pops one vector expectation per vec_count step and one run expectation per done rise.
   initial begin
      logic [15:0] pv;
      logic        pd;
      vec_exp_t    e;
      run_exp_t    r;
      pv = '0; pd = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && vec_count != pv && vec_count != 16'd0) begin
            if (vq.size() == 0) chk("vec_queue", 32'(vq.size()), 32'(1));
            else begin
               e = vq.pop_front();
               chk("vec_idx", 32'(vec_count), 32'(e.idx));
               chk("vec_a", 32'(A), 32'(e.a));
               chk("vec_b", 32'(B), 32'(e.b));
               chk("vec_err", 32'(err_count), 32'(e.err));
            end
         end
         if (rst_n && done && !pd) begin
            if (rq.size() == 0) chk("run_queue", 32'(rq.size()), 32'(1));
            else begin
               r = rq.pop_front();
               chk("done_cycle", 32'(cyc), 32'(r.cycle));
               chk("done_pass", 32'(pass), 32'(r.pass));
               chk("done_err", 32'(err_count), 32'(r.err));
               chk("done_vec", 32'(vec_count), 32'(r.vec));
               chk("done_busy", 32'(busy), 32'(0));
`ifdef CMP_BIST_FIRST_FAIL_EN
               chk("ff_valid", 32'(first_fail_valid), 32'(r.ffv));
               chk("ff_a", 32'(first_fail_a), 32'(r.ffa));
               chk("ff_b", 32'(first_fail_b), 32'(r.ffb));
               chk("ff_flags", 32'(first_fail_flags), 32'(r.fff));
`endif
            end
         end
         pv = vec_count;
         pd = done;
      end
   end

   initial begin
      seq_a[0] = 8'hA5; seq_a[1] = 8'hEA; seq_a[2] = 8'h75; seq_a[3] = 8'h82;
      seq_b[0] = 8'h5A; seq_b[1] = 8'hA5; seq_b[2] = 8'hEA; seq_b[3] = 8'h82;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_A", 32'(A), 32'(0));
      chk("rst_B", 32'(B), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_pass", 32'(pass), 32'(0));
      chk("rst_err", 32'(err_count), 32'(0));
      chk("rst_vec", 32'(vec_count), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      do_run(0, 1'b0, 1'b1, 1'b0);
      do_run(1, 1'b0, 1'b0, 1'b1);
      do_run(2, 1'b0, 1'b0, 1'b1);
      do_run(3, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         do_run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      // Abort partway through vector 5
      issue_start(0);
      wait_vec(5);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_A", 32'(A), 32'(0));
      chk("abort_B", 32'(B), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_vec", 32'(vec_count), 32'(0));
      chk("abort_err", 32'(err_count), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      vq.delete();
      rq.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_run(0, 1'b0, 1'b1, 1'b0);
      do_run(0, 1'b1, 1'b1, 1'b1);

      chk("vq_empty", 32'(vq.size()), 32'(0));
      chk("rq_empty", 32'(rq.size()), 32'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
